// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline slice.
//   - WORD_WIDTH / REG_ADDR_WIDTH : datapath and register-index widths
//   - state_e                     : MEM-stage access sequencer states
//   - is_word_aligned()           : checks the two low address bits
package mips_pkg;

  localparam int WORD_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_RESP = 1'b1
  } state_e;

  // A word access is legal only when both byte-offset bits are zero.
  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/mem_stage_access_unit.sv
// MEM-stage sequencer between the EX/MEM and MEM/WB pipeline registers.
// ALU results pass straight into MEM/WB; loads and stores go out over a
// valid/ready data-memory port while the upstream pipeline is stalled.
// Loads that see no response within TIMEOUT_CYCLES wait cycles are
// abandoned and raise a sticky bus_error; misaligned accesses are dropped
// with a one-cycle misaligned_error pulse.
// Ports:
//   clock, reset_n                  : clock, asynchronous active-low reset
//   MEM_*                           : EX/MEM pipeline register fields
//   dm_req_valid/write, dm_addr,
//   dm_wdata, dm_req_ready          : memory request channel
//   dm_resp_valid, dm_rdata         : memory read-response channel
//   stall                           : freeze PC, IF/ID, ID/EX, EX/MEM
//   WB_write_data/_reg_1/_enable    : MEM/WB pipeline register
//   misaligned_error, bus_error     : error indications
module mem_stage_access_unit
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [WORD_WIDTH-1:0]     MEM_alu_result,
  input  logic [WORD_WIDTH-1:0]     MEM_read_data_2,
  input  logic [REG_ADDR_WIDTH-1:0] MEM_write_reg_1,
  input  logic                      MEM_dm_write_enable,
  input  logic                      MEM_rm_write_data_source,
  input  logic                      MEM_rm_write_enable,
  output logic                      dm_req_valid,
  output logic                      dm_req_write,
  output logic [WORD_WIDTH-1:0]     dm_addr,
  output logic [WORD_WIDTH-1:0]     dm_wdata,
  input  logic                      dm_req_ready,
  input  logic                      dm_resp_valid,
  input  logic [WORD_WIDTH-1:0]     dm_rdata,
  output logic                      stall,
  output logic [WORD_WIDTH-1:0]     WB_write_data,
  output logic [REG_ADDR_WIDTH-1:0] WB_write_reg_1,
  output logic                      WB_rm_write_enable,
  output logic                      misaligned_error,
  output logic                      bus_error
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic                      store_s;
  logic                      load_s;
  logic                      memop_s;
  logic                      aligned_s;
  logic                      req_valid_s;
  logic                      stall_s;

  state_e                    state_r;
  state_e                    state_next_s;
  logic [CNT_W-1:0]          cnt_r;
  logic [CNT_W-1:0]          cnt_next_s;
  logic [REG_ADDR_WIDTH-1:0] dest_r;
  logic [REG_ADDR_WIDTH-1:0] dest_next_s;

  logic [WORD_WIDTH-1:0]     wb_data_next_s;
  logic [REG_ADDR_WIDTH-1:0] wb_reg_next_s;
  logic                      wb_we_next_s;
  logic                      mis_next_s;
  logic                      bus_next_s;

  // Instruction classification; a store wins over the load encoding.
  always_comb begin
    store_s   = MEM_dm_write_enable;
    load_s    = MEM_rm_write_data_source & MEM_rm_write_enable & ~MEM_dm_write_enable;
    memop_s   = store_s | load_s;
    aligned_s = is_word_aligned(MEM_alu_result[1:0]);
  end

  // Next-state, MEM/WB next value and handshake/stall decode.
  always_comb begin
    state_next_s   = state_r;
    cnt_next_s     = cnt_r;
    dest_next_s    = dest_r;
    wb_data_next_s = WB_write_data;
    wb_reg_next_s  = WB_write_reg_1;
    wb_we_next_s   = WB_rm_write_enable;
    mis_next_s     = 1'b0;
    bus_next_s     = bus_error;
    req_valid_s    = 1'b0;
    stall_s        = 1'b0;

    case (state_r)
      IDLE: begin
        if (!memop_s) begin
          wb_data_next_s = MEM_alu_result;
          wb_reg_next_s  = MEM_write_reg_1;
          wb_we_next_s   = MEM_rm_write_enable;
        end else if (!aligned_s) begin
          mis_next_s   = 1'b1;
          wb_we_next_s = 1'b0;
        end else if (store_s) begin
          // Both waiting and accepting edges leave a bubble in MEM/WB.
          req_valid_s  = 1'b1;
          stall_s      = ~dm_req_ready;
          wb_we_next_s = 1'b0;
        end else begin
          req_valid_s  = 1'b1;
          stall_s      = 1'b1;
          wb_we_next_s = 1'b0;
          if (dm_req_ready) begin
            // Destination captured here; the latched copy is authoritative
            // for the write-back once the response arrives.
            state_next_s = WAIT_RESP;
            cnt_next_s   = '0;
            dest_next_s  = MEM_write_reg_1;
          end else begin
            state_next_s = IDLE;
          end
        end
      end

      WAIT_RESP: begin
        if (dm_resp_valid) begin
          wb_data_next_s = dm_rdata;
          wb_reg_next_s  = dest_r;
          wb_we_next_s   = 1'b1;
          state_next_s   = IDLE;
        end else if (cnt_r == CNT_LAST) begin
          // Give up on the load; the pipeline resumes this same cycle.
          bus_next_s   = 1'b1;
          wb_we_next_s = 1'b0;
          state_next_s = IDLE;
        end else begin
          stall_s      = 1'b1;
          wb_we_next_s = 1'b0;
          cnt_next_s   = cnt_r + CNT_ONE;
        end
      end

      default: begin
        state_next_s = IDLE;
        cnt_next_s   = '0;
        wb_we_next_s = 1'b0;
      end
    endcase
  end

  // Combinational memory port and stall, forced quiet while in reset.
  always_comb begin
    dm_req_valid = req_valid_s & reset_n;
    stall        = stall_s & reset_n;
    dm_req_write = store_s;
    dm_addr      = MEM_alu_result;
    dm_wdata     = MEM_read_data_2;
  end

  // Sequencer state, timeout counter, latched destination and MEM/WB register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r            <= IDLE;
      cnt_r              <= '0;
      dest_r             <= '0;
      WB_write_data      <= '0;
      WB_write_reg_1     <= '0;
      WB_rm_write_enable <= 1'b0;
      misaligned_error   <= 1'b0;
      bus_error          <= 1'b0;
    end else begin
      state_r            <= state_next_s;
      cnt_r              <= cnt_next_s;
      dest_r             <= dest_next_s;
      WB_write_data      <= wb_data_next_s;
      WB_write_reg_1     <= wb_reg_next_s;
      WB_rm_write_enable <= wb_we_next_s;
      misaligned_error   <= mis_next_s;
      bus_error          <= bus_next_s;
    end
  end

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Self-checking bench for mem_stage_access_unit: directed scenarios followed
// by randomized instruction/memory traffic, all checked against a
// transaction-level reference model.
module tb_mem_stage_access_unit;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] MEM_alu_result;
  logic [31:0] MEM_read_data_2;
  logic [4:0]  MEM_write_reg_1;
  logic        MEM_dm_write_enable;
  logic        MEM_rm_write_data_source;
  logic        MEM_rm_write_enable;
  logic        dm_req_valid;
  logic        dm_req_write;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_req_ready;
  logic        dm_resp_valid;
  logic [31:0] dm_rdata;
  logic        stall;
  logic [31:0] WB_write_data;
  logic [4:0]  WB_write_reg_1;
  logic        WB_rm_write_enable;
  logic        misaligned_error;
  logic        bus_error;

  mem_stage_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clock                    (clock),
    .reset_n                  (reset_n),
    .MEM_alu_result           (MEM_alu_result),
    .MEM_read_data_2          (MEM_read_data_2),
    .MEM_write_reg_1          (MEM_write_reg_1),
    .MEM_dm_write_enable      (MEM_dm_write_enable),
    .MEM_rm_write_data_source (MEM_rm_write_data_source),
    .MEM_rm_write_enable      (MEM_rm_write_enable),
    .dm_req_valid             (dm_req_valid),
    .dm_req_write             (dm_req_write),
    .dm_addr                  (dm_addr),
    .dm_wdata                 (dm_wdata),
    .dm_req_ready             (dm_req_ready),
    .dm_resp_valid            (dm_resp_valid),
    .dm_rdata                 (dm_rdata),
    .stall                    (stall),
    .WB_write_data            (WB_write_data),
    .WB_write_reg_1           (WB_write_reg_1),
    .WB_rm_write_enable       (WB_rm_write_enable),
    .misaligned_error         (misaligned_error),
    .bus_error                (bus_error)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a load in flight plus how many response cycles it has waited.
  bit          m_inflight;
  int          m_waited;
  logic [4:0]  m_dest;
  logic [31:0] m_wb_data;
  logic [4:0]  m_wb_reg;
  logic        m_wb_we;
  logic        m_mis;
  logic        m_bus;
  logic        last_stall;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_inflight = 1'b0;
    m_waited   = 0;
    m_dest     = 5'd0;
    m_wb_data  = 32'd0;
    m_wb_reg   = 5'd0;
    m_wb_we    = 1'b0;
    m_mis      = 1'b0;
    m_bus      = 1'b0;
    last_stall = 1'b0;
  endtask

  task automatic set_inst(input int kind, input logic [31:0] a, input logic [31:0] d,
                          input logic [4:0] r, input logic rwe);
    MEM_alu_result  = a;
    MEM_read_data_2 = d;
    MEM_write_reg_1 = r;
    case (kind)
      1: begin // load
        MEM_dm_write_enable = 1'b0; MEM_rm_write_data_source = 1'b1; MEM_rm_write_enable = 1'b1;
      end
      2: begin // store
        MEM_dm_write_enable = 1'b1; MEM_rm_write_data_source = 1'b0; MEM_rm_write_enable = 1'b0;
      end
      default: begin // ALU op
        MEM_dm_write_enable = 1'b0; MEM_rm_write_data_source = 1'b0; MEM_rm_write_enable = rwe;
      end
    endcase
  endtask

  // One clock cycle: check combinational outputs before the edge, then
  // advance the model and check the registered outputs after the edge.
  task automatic step();
    logic st, ld, mo, mis_addr, e_valid, e_stall;
    @(negedge clock);
    st       = MEM_dm_write_enable;
    ld       = MEM_rm_write_data_source & MEM_rm_write_enable & ~st;
    mo       = st | ld;
    mis_addr = (MEM_alu_result[1:0] != 2'b00);
    if (!m_inflight) begin
      e_valid = mo & ~mis_addr;
      e_stall = e_valid & (ld | ~dm_req_ready);
    end else begin
      e_valid = 1'b0;
      e_stall = ~dm_resp_valid & (m_waited + 1 < TO);
    end
    check_val("dm_req_valid", dm_req_valid, e_valid);
    check_val("stall", stall, e_stall);
    if (e_valid) begin
      check_val("dm_addr", dm_addr, MEM_alu_result);
      check_val("dm_wdata", dm_wdata, MEM_read_data_2);
      check_val("dm_req_write", dm_req_write, st);
    end
    last_stall = e_stall;

    m_mis = 1'b0;
    if (!m_inflight) begin
      if (!mo) begin
        m_wb_data = MEM_alu_result; m_wb_reg = MEM_write_reg_1; m_wb_we = MEM_rm_write_enable;
      end else if (mis_addr) begin
        m_wb_we = 1'b0; m_mis = 1'b1;
      end else begin
        m_wb_we = 1'b0;
        if (ld && dm_req_ready) begin
          m_inflight = 1'b1; m_waited = 0; m_dest = MEM_write_reg_1;
        end
      end
    end else if (dm_resp_valid) begin
      m_wb_data = dm_rdata; m_wb_reg = m_dest; m_wb_we = 1'b1; m_inflight = 1'b0;
    end else begin
      m_waited++;
      m_wb_we = 1'b0;
      if (m_waited >= TO) begin
        m_bus = 1'b1; m_inflight = 1'b0;
      end
    end

    @(posedge clock);
    #1;
    check_val("WB_write_data", WB_write_data, m_wb_data);
    check_val("WB_write_reg_1", WB_write_reg_1, m_wb_reg);
    check_val("WB_rm_write_enable", WB_rm_write_enable, m_wb_we);
    check_val("misaligned_error", misaligned_error, m_mis);
    check_val("bus_error", bus_error, m_bus);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_valid"}, dm_req_valid, 32'd0);
    check_val({tag, "_stall"}, stall, 32'd0);
    check_val({tag, "_wbdata"}, WB_write_data, 32'd0);
    check_val({tag, "_wbreg"}, WB_write_reg_1, 32'd0);
    check_val({tag, "_wbwe"}, WB_rm_write_enable, 32'd0);
    check_val({tag, "_mis"}, misaligned_error, 32'd0);
    check_val({tag, "_bus"}, bus_error, 32'd0);
  endtask

  int stall_cnt;
  int valid_cnt;

  initial begin
    reset_n       = 1'b0;
    set_inst(0, 32'd0, 32'd0, 5'd0, 1'b0);
    dm_req_ready  = 1'b0;
    dm_resp_valid = 1'b0;
    dm_rdata      = 32'd0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    set_inst(1, 32'h40, 32'h1, 5'd2, 1'b1);  // aligned load present during reset
    dm_req_ready = 1'b1;
    #1;
    check_all_zero("reset");
    set_inst(0, 32'd0, 32'd0, 5'd0, 1'b0);
    reset_n = 1'b1;

    // ALU op passes through in one cycle.
    set_inst(0, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
    step();
    check_val("alu_wb_data", WB_write_data, 32'h0000_1234);
    check_val("alu_wb_reg", WB_write_reg_1, 32'd5);
    check_val("alu_wb_we", WB_rm_write_enable, 32'd1);

    // Store: ready low for two cycles, then high.
    set_inst(2, 32'h40, 32'hDEAD_BEEF, 5'd0, 1'b0);
    valid_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      dm_req_ready = (i == 2);
      step();
      valid_cnt += 1;
    end
    check_val("store_wb_we", WB_rm_write_enable, 32'd0);
    dm_req_ready = 1'b0;

    // Load: accepted at once, response in the fourth wait cycle.
    set_inst(1, 32'h80, 32'h0, 5'd9, 1'b1);
    dm_req_ready = 1'b1;
    stall_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      dm_resp_valid = (i == 4);
      dm_rdata      = (i == 4) ? 32'hCAFE_F00D : 32'h1111_1111;
      step();
      if (last_stall) stall_cnt++;
    end
    check_val("load_stall_cycles", stall_cnt, 32'd4);
    check_val("load_wb_data", WB_write_data, 32'hCAFE_F00D);
    check_val("load_wb_reg", WB_write_reg_1, 32'd9);
    dm_resp_valid = 1'b0;

    // Misaligned load is dropped with a single-cycle pulse.
    set_inst(1, 32'h82, 32'h0, 5'd7, 1'b1);
    step();
    check_val("mis_pulse", misaligned_error, 32'd1);
    set_inst(0, 32'h0, 32'h0, 5'd0, 1'b0);
    step();
    check_val("mis_pulse_end", misaligned_error, 32'd0);

    // Load that never gets a response times out.
    set_inst(1, 32'h100, 32'h0, 5'd3, 1'b1);
    dm_req_ready = 1'b1;
    stall_cnt = 0;
    for (int i = 0; i < 1 + TO; i++) begin
      step();
      if (last_stall) stall_cnt++;
    end
    check_val("timeout_stall_cycles", stall_cnt, TO);
    check_val("timeout_bus_error", bus_error, 32'd1);
    set_inst(0, 32'h0000_0abc, 32'h0, 5'd12, 1'b1);
    step();
    check_val("after_timeout_alu", WB_write_data, 32'h0000_0abc);

    // Reset in the middle of a load, then a stray response.
    set_inst(1, 32'h200, 32'h0, 5'd4, 1'b1);
    dm_req_ready = 1'b1;
    step();
    step();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all_zero("midreset");
    set_inst(0, 32'h0, 32'h0, 5'd0, 1'b0);
    dm_resp_valid = 1'b1;
    dm_rdata      = 32'hBAD0_BAD0;
    #1;
    reset_n = 1'b1;
    step();
    check_val("stray_resp_wb_we", WB_rm_write_enable, 32'd0);
    dm_resp_valid = 1'b0;

    // Randomized traffic; EX/MEM holds its contents while stalled.
    for (int c = 0; c < 800; c++) begin
      if (!last_stall) begin
        int kind;
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        kind = $urandom_range(0, 3);
        if (kind == 3) begin
          MEM_alu_result           = a;
          MEM_read_data_2          = $urandom;
          MEM_write_reg_1          = 5'($urandom_range(0, 31));
          MEM_dm_write_enable      = 1'($urandom_range(0, 1));
          MEM_rm_write_data_source = 1'($urandom_range(0, 1));
          MEM_rm_write_enable      = 1'($urandom_range(0, 1));
        end else begin
          set_inst(kind, a, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end
      end
      dm_req_ready  = ($urandom_range(0, 3) != 0);
      dm_resp_valid = ($urandom_range(0, 2) == 0);
      dm_rdata      = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
